retire_rr_sched8: RTL and testbench
===================================

RETIRE_RR_SCHED8 -- requirements
Module: retire_rr_sched8

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12: payload width per requester.
REQ-002 SHALL have `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have `i_valid_8`, input, 8 bits: per-requester valid.
REQ-005 SHALL have `i_data_flat`, input, 8*DATA_WIDTH bits: requester k payload in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-006 SHALL have `o_ready_8`, output, 8 bits: per-requester ready.
REQ-007 SHALL have `o_valid`, output, 1 bit: merged output valid.
REQ-008 SHALL have `i_ready`, input, 1 bit: downstream ready.
REQ-009 SHALL have `o_data`, output, DATA_WIDTH bits: merged payload.
REQ-010 SHALL have `o_grant_id`, output, 3 bits: source index of the current `o_data`.
REQ-011 SHALL have `o_busy`, output, 1 bit: high when any lane is pending or `o_valid` is high.
REQ-012 SHALL have `o_grant_cnt`, output, 16 bits: performance counter (see Configuration).

Function
REQ-013 SHALL give each lane k a one-entry buffer (`pend[k]`, `buf[k]`), with `o_ready_8[k] = ~pend[k]`.
REQ-014 SHALL, on `i_valid_8[k] & o_ready_8[k]`, capture the payload into `buf[k]` and set `pend[k]` at the next edge.
REQ-015 SHALL define output slot free as `~o_valid | i_ready`.
REQ-016 SHALL, when the slot is free and any `pend` bit is set, grant the first pending lane scanning ptr, ptr+1, …, ptr+7 modulo 8.
REQ-017 SHALL, on a grant to lane g, at the same edge: load `o_data`/`o_grant_id` with `buf[g]`/g, set `o_valid`, clear `pend[g]`, and set ptr to (g+1) mod 8.
REQ-018 SHALL, when the slot is free and no lane is pending, clear `o_valid` at the next edge and leave ptr unchanged.
REQ-019 SHALL hold `o_data`, `o_grant_id` and `o_valid` stable while `o_valid & ~i_ready`.
REQ-020 SHALL have a minimum latency of 2 cycles from input handshake to `o_valid`, and sustain one output per cycle when `i_ready` is held high and requests are backlogged.
REQ-021 SHALL not accept lane g in the cycle it is granted; lane g's ready rises the following cycle.
REQ-022 SHALL serve every pending lane within 8 grants (no starvation).
REQ-023 SHALL wrap from lane 7 to lane 0 with no idle cycle.

Reset
REQ-024 SHALL, while `rst` is high at an edge: clear `pend`, ptr, `o_valid`, `o_data`, `o_grant_id` and `o_grant_cnt`; `o_ready_8` is then 8'hFF.
REQ-025 SHALL, when reset is asserted mid-transfer, discard buffered and output data with no partial handshake completing in that cycle.

Configuration
REQ-026 SHALL, with macro RETIRE_RR_SCHED_PERF_EN defined, increment `o_grant_cnt` on each `o_valid & i_ready` cycle, saturating at 16'hFFFF.
REQ-027 SHALL, without RETIRE_RR_SCHED_PERF_EN, tie `o_grant_cnt` to 0 and implement no counter logic.

Structure
REQ-028 SHALL take lane count (8), index width (3) and counter width (16) as constants from shared package `retire_sched_pkg`.
REQ-029 SHALL implement the rotating-priority pick as combinational sub-module `rr_pick8`, with inputs req[8] and ptr[3] and outputs gnt_onehot[8], gnt_id[3] and any.

Verification
REQ-030 SHALL verify single request: after reset, lane 3 sends 12'hABC at cycle t with `i_ready` = 1 -> `o_valid` = 1, `o_data` = 12'hABC, `o_grant_id` = 3 at cycle t+2.
REQ-031 SHALL verify round robin: all 8 lanes valid in the same cycle with `i_ready` = 1 -> grant IDs 0,1,…,7 on 8 consecutive cycles; lane 0 is not regranted before lane 7.
REQ-032 SHALL verify rotation after a grant: ptr = 5 after granting lane 4, lanes 2 and 6 pending -> lane 6 granted first, then lane 2.
REQ-033 SHALL verify backpressure: `i_ready` = 0 for 4 cycles with `o_valid` high -> `o_data`/`o_grant_id` unchanged, no `pend` bit cleared, `o_ready_8` of the pending lanes stays 0.
REQ-034 SHALL verify mid-operation reset: `rst` pulsed for 1 cycle with 3 lanes pending -> next cycle `o_valid` = 0, `o_ready_8` = 8'hFF, `o_busy` = 0, `o_grant_cnt` = 0.
REQ-035 SHALL verify the counter (RETIRE_RR_SCHED_PERF_EN defined): 70000 back-to-back transfers -> `o_grant_cnt` = 16'hFFFF; with the macro undefined -> `o_grant_cnt` stays 0.

Source files
------------

// File: rtl/retire_sched_pkg.sv
// Shared constants for the retire-stage round-robin scheduler family.
package retire_sched_pkg;

    localparam int NUM_LANES = 8;
    localparam int ID_W      = 3;
    localparam int CNT_W     = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating-priority picker: first set req bit scanning ptr, ptr+1, ... mod 8.
module rr_pick8
    import retire_sched_pkg::*;
(
    input  logic [NUM_LANES-1:0] req,
    input  logic [ID_W-1:0]      ptr,
    output logic [NUM_LANES-1:0] gnt_onehot,
    output logic [ID_W-1:0]      gnt_id,
    output logic                 any
);

    logic [ID_W-1:0] idx;

    // The 3-bit index sum wraps naturally, giving the modulo-8 scan order.
    always_comb begin
        gnt_onehot = '0;
        gnt_id     = '0;
        any        = 1'b0;
        idx        = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            idx = ptr + ID_W'(i);
            if (!any && req[idx]) begin
                any             = 1'b1;
                gnt_id          = idx;
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/retire_rr_sched8.sv
// Eight-lane round-robin merge with one-entry buffer per lane and registered output slot.
// Optional saturating grant counter enabled by macro RETIRE_RR_SCHED_PERF_EN.
module retire_rr_sched8
    import retire_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 12
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_LANES-1:0]           i_valid_8,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] i_data_flat,
    output logic [NUM_LANES-1:0]           o_ready_8,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [DATA_WIDTH-1:0]          o_data,
    output logic [ID_W-1:0]                o_grant_id,
    output logic                           o_busy,
    output logic [CNT_W-1:0]               o_grant_cnt
);

    logic [NUM_LANES-1:0]  pend_q, pend_d;
    logic [DATA_WIDTH-1:0] data_buf_q [NUM_LANES];
    logic [DATA_WIDTH-1:0] data_buf_d [NUM_LANES];
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic                  o_valid_q, o_valid_d;
    logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
    logic [ID_W-1:0]       o_grant_id_q, o_grant_id_d;

    logic [NUM_LANES-1:0]  gnt_onehot;
    logic [ID_W-1:0]       gnt_id;
    logic                  gnt_any;
    logic                  slot_free;

    rr_pick8 u_pick (
        .req        (pend_q),
        .ptr        (ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_id     (gnt_id),
        .any        (gnt_any)
    );

    assign slot_free = ~o_valid_q | i_ready;

    // A granted lane is still pending this cycle, so it cannot be re-accepted until the next one.
    always_comb begin
        pend_d       = pend_q;
        data_buf_d   = data_buf_q;
        ptr_d        = ptr_q;
        o_valid_d    = o_valid_q;
        o_data_d     = o_data_q;
        o_grant_id_d = o_grant_id_q;
        if (slot_free) begin
            if (gnt_any) begin
                o_valid_d    = 1'b1;
                o_data_d     = data_buf_q[gnt_id];
                o_grant_id_d = gnt_id;
                ptr_d        = gnt_id + ID_W'(1);
                pend_d       = pend_d & ~gnt_onehot;
            end else begin
                o_valid_d = 1'b0;
            end
        end
        for (int k = 0; k < NUM_LANES; k++) begin
            if (i_valid_8[k] && !pend_q[k]) begin
                pend_d[k]     = 1'b1;
                data_buf_d[k] = i_data_flat[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q       <= '0;
            ptr_q        <= '0;
            o_valid_q    <= 1'b0;
            o_data_q     <= '0;
            o_grant_id_q <= '0;
            for (int k = 0; k < NUM_LANES; k++) data_buf_q[k] <= '0;
        end else begin
            pend_q       <= pend_d;
            ptr_q        <= ptr_d;
            o_valid_q    <= o_valid_d;
            o_data_q     <= o_data_d;
            o_grant_id_q <= o_grant_id_d;
            data_buf_q   <= data_buf_d;
        end
    end

`ifdef RETIRE_RR_SCHED_PERF_EN
    logic [CNT_W-1:0] grant_cnt_q, grant_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        if (o_valid_q && i_ready && grant_cnt_q != CNT_MAX)
            grant_cnt_d = grant_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) grant_cnt_q <= '0;
        else     grant_cnt_q <= grant_cnt_d;
    end

    assign o_grant_cnt = grant_cnt_q;
`else
    assign o_grant_cnt = '0;
`endif

    assign o_ready_8  = ~pend_q;
    assign o_valid    = o_valid_q;
    assign o_data     = o_data_q;
    assign o_grant_id = o_grant_id_q;
    assign o_busy     = (|pend_q) | o_valid_q;

endmodule

// File: tb/tb_retire_rr_sched8.sv
// Randomized and directed bench for retire_rr_sched8 against a behavioural lane/slot model.
// Counter expectations follow macro RETIRE_RR_SCHED_PERF_EN.
module tb_retire_rr_sched8;

    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    i_valid_8;
    logic [8*DW-1:0] i_data_flat;
    logic [7:0]    o_ready_8;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
    logic [2:0]    o_grant_id;
    logic          o_busy;
    logic [15:0]   o_grant_cnt;

    int checks = 0;
    int fails  = 0;

    // Behavioural model state
    bit          m_pend [8];
    logic [DW-1:0] m_buf [8];
    int          m_ptr;
    bit          m_ov;
    logic [DW-1:0] m_od;
    int          m_id;
    int          m_cnt;

    retire_rr_sched8 #(.DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid_8   (i_valid_8),
        .i_data_flat (i_data_flat),
        .o_ready_8   (o_ready_8),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_grant_id  (o_grant_id),
        .o_busy      (o_busy),
        .o_grant_cnt (o_grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] modelReady();
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = !m_pend[k];
        return r;
    endfunction

    function automatic bit modelBusy();
        bit b = m_ov;
        for (int k = 0; k < 8; k++) b |= m_pend[k];
        return b;
    endfunction

    // Compare DUT against model for the current cycle, drive inputs, advance one edge.
    task automatic applyStimulus(input logic [7:0] v, input logic [8*DW-1:0] d,
                                 input logic rdy, input logic r);
        bit newp [8];
        int g;
        checkOutput("o_valid",     32'(o_valid),     32'(m_ov));
        checkOutput("o_data",      32'(o_data),      32'(m_od));
        checkOutput("o_grant_id",  32'(o_grant_id),  32'(m_id));
        checkOutput("o_ready_8",   32'(o_ready_8),   32'(modelReady()));
        checkOutput("o_busy",      32'(o_busy),      32'(modelBusy()));
        checkOutput("o_grant_cnt", 32'(o_grant_cnt), 32'(m_cnt));
        i_valid_8   = v;
        i_data_flat = d;
        i_ready     = rdy;
        rst         = r;
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 8; k++) m_pend[k] = 0;
            m_ptr = 0; m_ov = 0; m_od = '0; m_id = 0; m_cnt = 0;
        end else begin
`ifdef RETIRE_RR_SCHED_PERF_EN
            if (m_ov && rdy && m_cnt < 65535) m_cnt++;
`endif
            newp = m_pend;
            if (!m_ov || rdy) begin
                g = -1;
                for (int i = 0; i < 8 && g < 0; i++)
                    if (m_pend[(m_ptr + i) % 8]) g = (m_ptr + i) % 8;
                if (g >= 0) begin
                    m_ov = 1; m_od = m_buf[g]; m_id = g;
                    newp[g] = 0; m_ptr = (g + 1) % 8;
                end else begin
                    m_ov = 0;
                end
            end
            for (int k = 0; k < 8; k++)
                if (v[k] && !m_pend[k]) begin
                    newp[k] = 1;
                    m_buf[k] = d[k*DW +: DW];
                end
            m_pend = newp;
        end
        @(negedge clk);
    endtask

    function automatic logic [8*DW-1:0] randData();
        return {$urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [8*DW-1:0] d;
        logic [DW-1:0]   held_data;
        for (int k = 0; k < 8; k++) begin m_pend[k] = 0; m_buf[k] = '0; end
        m_ptr = 0; m_ov = 0; m_od = '0; m_id = 0; m_cnt = 0;
        rst = 1'b1; i_valid_8 = '0; i_data_flat = '0; i_ready = 1'b0;
        @(negedge clk);
        applyStimulus(8'h00, '0, 1'b0, 1'b1);
        checkOutput("reset_ready", 32'(o_ready_8), 32'hFF);
        checkOutput("reset_valid", 32'(o_valid), 32'h0);

        // Single request on lane 3: visible two cycles later
        d = '0;
        d[3*DW +: DW] = 12'hABC;
        applyStimulus(8'h08, d, 1'b1, 1'b0);
        applyStimulus(8'h00, '0, 1'b1, 1'b0);
        checkOutput("single_valid", 32'(o_valid), 32'h1);
        checkOutput("single_data", 32'(o_data), 32'hABC);
        checkOutput("single_id", 32'(o_grant_id), 32'h3);
        applyStimulus(8'h00, '0, 1'b1, 1'b0);

        // All lanes at once from ptr 0: ids 0..7 on consecutive cycles
        applyStimulus(8'h00, '0, 1'b1, 1'b1);
        applyStimulus(8'hFF, randData(), 1'b1, 1'b0);
        applyStimulus(8'h00, '0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checkOutput("rr_valid", 32'(o_valid), 32'h1);
            checkOutput("rr_id", 32'(o_grant_id), 32'(i));
            applyStimulus(8'h00, '0, 1'b1, 1'b0);
        end
        checkOutput("rr_drained", 32'(o_valid), 32'h0);

        // Rotation: after lane 4, lanes 2 and 6 -> 6 then 2
        applyStimulus(8'h00, '0, 1'b1, 1'b1);
        applyStimulus(8'h10, randData(), 1'b1, 1'b0);
        applyStimulus(8'h00, '0, 1'b1, 1'b0);
        checkOutput("rot_first", 32'(o_grant_id), 32'h4);
        applyStimulus(8'h44, randData(), 1'b1, 1'b0);
        applyStimulus(8'h00, '0, 1'b1, 1'b0);
        checkOutput("rot_6", 32'(o_grant_id), 32'h6);
        applyStimulus(8'h00, '0, 1'b1, 1'b0);
        checkOutput("rot_2", 32'(o_grant_id), 32'h2);
        applyStimulus(8'h00, '0, 1'b1, 1'b0);

        // Backpressure: output and pending lanes held for 4 cycles
        applyStimulus(8'h00, '0, 1'b1, 1'b1);
        applyStimulus(8'h07, randData(), 1'b0, 1'b0);
        applyStimulus(8'h00, '0, 1'b0, 1'b0);
        held_data = o_data;
        checkOutput("bp_data_model", 32'(held_data), 32'(m_buf[0]));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h00, '0, 1'b0, 1'b0);
            checkOutput("bp_data", 32'(o_data), 32'(held_data));
            checkOutput("bp_id", 32'(o_grant_id), 32'h0);
            checkOutput("bp_ready", 32'(o_ready_8), 32'hF9);
        end

        // Reset with lanes 0,1,2 pending and output held
        applyStimulus(8'h01, randData(), 1'b0, 1'b0);
        checkOutput("mid_pend", 32'(o_ready_8), 32'hF8);
        applyStimulus(8'hFF, randData(), 1'b1, 1'b1);
        checkOutput("mrst_valid", 32'(o_valid), 32'h0);
        checkOutput("mrst_ready", 32'(o_ready_8), 32'hFF);
        checkOutput("mrst_busy", 32'(o_busy), 32'h0);
        checkOutput("mrst_cnt", 32'(o_grant_cnt), 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++)
            applyStimulus(8'($urandom), randData(), 1'($urandom_range(0, 9) < 7),
                          1'($urandom_range(0, 99) == 0));

        // Counter saturation under back-to-back traffic
        applyStimulus(8'h00, '0, 1'b1, 1'b1);
        for (int i = 0; i < 70000; i++)
            applyStimulus(8'hFF, randData(), 1'b1, 1'b0);
`ifdef RETIRE_RR_SCHED_PERF_EN
        checkOutput("cnt_sat", 32'(o_grant_cnt), 32'hFFFF);
`else
        checkOutput("cnt_zero", 32'(o_grant_cnt), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
